o_ddr_serializer: RTL and testbench

O_DDR_SERIALIZER -- requirements
Module: o_ddr_serializer

---
 rtl/o_ddr_serializer_pkg.sv | 24 ++
 rtl/o_ddr_serializer_if.sv | 17 +
 rtl/o_ddr_ser_lane.sv | 68 ++++++
 rtl/o_ddr_serializer.sv | 142 ++++++++++++++
 tb/tb_o_ddr_serializer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/o_ddr_serializer_pkg.sv
// Shared types and helpers for the output DDR/SDR serializer.
package o_ddr_serializer_pkg;

    // Control FSM states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Legal values of the DATA_RATE parameter.
    localparam string RATE_DDR = "DDR";
    localparam string RATE_SDR = "SDR";

    // Bits emitted per lane per clock cycle for a given data rate.
    function automatic int bits_per_cycle(input string rate);
        return (rate == RATE_SDR) ? 1 : 2;
    endfunction

    // True when the data rate string names a supported mode.
    function automatic bit rate_is_legal(input string rate);
        return (rate == RATE_DDR) || (rate == RATE_SDR);
    endfunction

endpackage

// File: rtl/o_ddr_serializer_if.sv
// Parallel word handshake into the serializer.
// Valid/ready: the source raises D_VALID with D stable and holds both until a
// rising edge where D_VALID && D_READY; that edge is the transfer. D_READY
// does not depend on D_VALID.
interface o_ddr_serializer_if #(
    parameter int DW = 8
);
    import o_ddr_serializer_pkg::*;

    logic [DW-1:0] D;
    logic          D_VALID;
    logic          D_READY;

    modport master (output D, output D_VALID, input D_READY);
    modport slave  (input D, input D_VALID, output D_READY);

endinterface

// File: rtl/o_ddr_ser_lane.sv
// One serializer lane: holding register, shift register and registered
// rise/fall output pair. Sequencing comes from the control FSM in the top.
module o_ddr_ser_lane
    import o_ddr_serializer_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter int   B        = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_accept,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_load,
    input  logic             i_advance,
    input  logic             i_go_idle,
    output logic [1:0]       o_q
);

    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_shift;
    logic [1:0]       r_q;
    logic [1:0]       w_hold_pair;
    logic [1:0]       w_shift_pair;

    // Pair layout is {fall, rise}; SDR drives the same bit on both halves.
    generate
        if (B == 2) begin : g_ddr
            assign w_hold_pair  = r_hold[1:0];
            assign w_shift_pair = r_shift[1:0];
        end else begin : g_sdr
            assign w_hold_pair  = {2{r_hold[0]}};
            assign w_shift_pair = {2{r_shift[0]}};
        end
    endgenerate

    // Capture an accepted word; contents are don't-care until hold is valid.
    always_ff @(posedge i_clk) begin
        if (i_accept) begin
            r_hold <= i_d;
        end
    end

    // Slice 0 goes straight to Q on load, so the shifter keeps the remainder.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_shift <= r_hold >> B;
        end else if (i_advance) begin
            r_shift <= r_shift >> B;
        end
    end

    // Output pair register, idle level whenever nothing is shifting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= {2{IDLE_VAL}};
        end else if (i_load) begin
            r_q <= w_hold_pair;
        end else if (i_advance) begin
            r_q <= w_shift_pair;
        end else if (i_go_idle) begin
            r_q <= {2{IDLE_VAL}};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/o_ddr_serializer.sv
// Parallel-to-serial converter feeding downstream O_DDR primitives. Each word
// plays out as S contiguous slices; a word held before the last slice
// follows with no gap.
module o_ddr_serializer
    import o_ddr_serializer_pkg::*;
#(
    parameter int    WIDTH     = 8,
    parameter int    NUM_CH    = 1,
    parameter string DATA_RATE = "DDR",
    parameter logic  IDLE_VAL  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic                  UF_CLR,
    o_ddr_serializer_if.slave     s_in,
    output logic [2*NUM_CH-1:0]   Q,
    output logic                  UNDERFLOW,
    output logic                  BUSY,
    output state_t                DBG_STATE
);

    localparam int B     = bits_per_cycle(DATA_RATE);
    localparam int S     = WIDTH / B;
    localparam int CNT_W = $clog2(S + 1);
    localparam logic [CNT_W-1:0] S_C   = CNT_W'(S);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    generate
        if (WIDTH < 2 || NUM_CH < 1 || !rate_is_legal(DATA_RATE) ||
            (B == 2 && (WIDTH % 2) != 0)) begin : g_bad_param
            $error("o_ddr_serializer: illegal WIDTH/NUM_CH/DATA_RATE combination");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_hold_valid;
    logic             r_underflow;
    logic             w_load;
    logic             w_accept;
    logic             w_advance;
    logic             w_go_idle;
    logic             w_uf_set;

    // A held word moves to the shifter when idle or on the last slice.
    assign w_load   = EN && r_hold_valid && (r_state == IDLE || r_cnt == S_C);
    assign s_in.D_READY = !r_hold_valid || w_load;
    assign w_accept = s_in.D_VALID && s_in.D_READY;
    assign w_uf_set = (r_state == SHIFT) && (r_cnt == S_C) && EN && !r_hold_valid;

    // Next-state, slot counter and lane strobes.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_advance  = 1'b0;
        w_go_idle  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nx = SHIFT;
                    w_cnt_nx   = ONE_C;
                end
            end
            SHIFT: begin
                if (w_load) begin
                    w_cnt_nx = ONE_C;
                end else if (r_cnt != S_C) begin
                    w_advance = 1'b1;
                    w_cnt_nx  = r_cnt + ONE_C;
                end else begin
                    w_go_idle  = 1'b1;
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // State and slot counter registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Shared holding-register valid: a refill on the load edge keeps it set.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hold_valid <= 1'b0;
        end else if (w_accept) begin
            r_hold_valid <= 1'b1;
        end else if (w_load) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Sticky underflow; a set on the same edge as a clear takes priority.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_underflow <= 1'b0;
        end else if (w_uf_set) begin
            r_underflow <= 1'b1;
        end else if (UF_CLR) begin
            r_underflow <= 1'b0;
        end
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
            o_ddr_ser_lane #(
                .WIDTH    (WIDTH),
                .B        (B),
                .IDLE_VAL (IDLE_VAL)
            ) u_lane (
                .i_clk     (CLK),
                .i_rst_n   (RST_N),
                .i_accept  (w_accept),
                .i_d       (s_in.D[c*WIDTH +: WIDTH]),
                .i_load    (w_load),
                .i_advance (w_advance),
                .i_go_idle (w_go_idle),
                .o_q       (Q[2*c +: 2])
            );
        end
    endgenerate

    assign UNDERFLOW = r_underflow;
    assign BUSY      = (r_state == SHIFT) || r_hold_valid;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_o_ddr_serializer.sv
// Directed bench for o_ddr_serializer: a DDR 2x8 instance and an SDR 1x4 one.
module tb_o_ddr_serializer;
  import o_ddr_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic uf_clr = 1'b0;
  logic uf_clr_s = 1'b0;
  logic [3:0] q;
  logic [1:0] q_s;
  logic uf, busy, uf_s, busy_s;
  state_t st, st_s;

  int checks = 0;
  int errors = 0;

  logic cap_on = 1'b0;
  logic [3:0] obs_q[$];
  logic [3:0] exp_q[$];

  o_ddr_serializer_if #(.DW(16)) bus ();
  o_ddr_serializer_if #(.DW(4))  bus_s ();

  o_ddr_serializer #(.WIDTH(8), .NUM_CH(2), .DATA_RATE("DDR"), .IDLE_VAL(1'b0)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .UF_CLR(uf_clr), .s_in(bus),
    .Q(q), .UNDERFLOW(uf), .BUSY(busy), .DBG_STATE(st)
  );

  o_ddr_serializer #(.WIDTH(4), .NUM_CH(1), .DATA_RATE("SDR"), .IDLE_VAL(1'b0)) dut_s (
    .CLK(clk), .RST_N(rst_n), .EN(en), .UF_CLR(uf_clr_s), .s_in(bus_s),
    .Q(q_s), .UNDERFLOW(uf_s), .BUSY(busy_s), .DBG_STATE(st_s)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // stream monitor
  always @(negedge clk) begin
    if (cap_on) obs_q.push_back(q);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver: offer a word, hold it until the transfer edge
  task automatic send_word(input logic [15:0] d);
    logic rdy;
    logic done;
    done = 1'b0;
    bus.D = d;
    bus.D_VALID = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rdy = bus.D_READY;
      tick();
      if (rdy) begin
        done = 1'b1;
        break;
      end
    end
    bus.D_VALID = 1'b0;
    check("send_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic clear_uf();
    uf_clr = 1'b1;
    tick();
    uf_clr = 1'b0;
    check("uf_cleared", {31'd0, uf}, 32'd0);
  endtask

  task automatic start_capture();
    obs_q.delete();
    exp_q.delete();
    cap_on = 1'b1;
  endtask

  // scoreboard: compare the captured Q stream with the expected queue
  task automatic finish_capture(input string name, input int n);
    for (int i = 0; i < 200; i++) begin
      if (obs_q.size() >= n) break;
      tick();
    end
    cap_on = 1'b0;
    check({name, "_len"}, obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      check($sformatf("%s_q%0d", name, i), {28'd0, obs_q[i]}, {28'd0, exp_q[i]});
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic [15:0] exp_q;  // slice k at [4k +: 4], Q = {lane1 {fall,rise}, lane0 {fall,rise}}
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [3:0] acc;

    vecs[0] = '{d: 16'h00B4, exp_q: 16'h2310};
    vecs[1] = '{d: 16'h5AFF, exp_q: 16'h77BB};
    vecs[2] = '{d: 16'hC31E, exp_q: 16'hC13E};
    vecs[3] = '{d: 16'hFF00, exp_q: 16'hCCCC};

    bus.D = '0;
    bus.D_VALID = 1'b1;  // offered during reset, must not be captured
    bus_s.D = '0;
    bus_s.D_VALID = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_q", {28'd0, q}, 32'd0);
    check("rst_uf", {31'd0, uf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, bus.D_READY}, 32'd1);
    check("rst_state", {31'd0, st}, {31'd0, IDLE});
    bus.D_VALID = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // table-driven single words, UF_CLR held across the set edge
    for (int v = 0; v < 4; v++) begin
      send_word(vecs[v].d);
      check($sformatf("v%0d_pre", v), {28'd0, q}, 32'd0);
      for (int k = 0; k < 4; k++) begin
        tick();
        check($sformatf("v%0d_s%0d", v, k), {28'd0, q}, {28'd0, vecs[v].exp_q[4*k +: 4]});
      end
      check($sformatf("v%0d_uf_before", v), {31'd0, uf}, 32'd0);
      check($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd1);
      uf_clr = 1'b1;
      tick();
      check($sformatf("v%0d_idle", v), {28'd0, q}, 32'd0);
      check($sformatf("v%0d_uf_set_wins", v), {31'd0, uf}, 32'd1);
      check($sformatf("v%0d_busy_idle", v), {31'd0, busy}, 32'd0);
      tick();
      uf_clr = 1'b0;
      check($sformatf("v%0d_uf_clr", v), {31'd0, uf}, 32'd0);
    end

    // back-to-back 0x01 then 0x80
    start_capture();
    exp_q = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
    send_word(16'h0001);
    send_word(16'h0080);
    repeat (7) tick();
    check("b2b_uf_before_last", {31'd0, uf}, 32'd0);
    tick();
    check("b2b_uf_after_last", {31'd0, uf}, 32'd1);
    finish_capture("b2b", 11);
    clear_uf();

    // three words offered back-to-back
    start_capture();
    exp_q = '{4'h0, 4'h0,
              4'h3, 4'h2, 4'h1, 4'h0,
              4'h0, 4'h1, 4'h2, 4'h3,
              4'h0, 4'h3, 4'h1, 4'h2,
              4'h0};
    send_word(16'h001B);
    send_word(16'h00E4);
    check("three_ready_low", {31'd0, bus.D_READY}, 32'd0);
    send_word(16'h009C);
    finish_capture("three", 15);
    tick();
    check("three_uf", {31'd0, uf}, 32'd1);
    clear_uf();

    // reset during slice 2 with a second word held
    send_word(16'h00FF);
    send_word(16'h0055);
    tick();
    tick();
    check("rst_mid_s2", {28'd0, q}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_q", {28'd0, q}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ready", {31'd0, bus.D_READY}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc = acc | q;
    end
    check("rst_no_residual", {28'd0, acc}, 32'd0);
    check("rst_after_busy", {31'd0, busy}, 32'd0);
    check("rst_after_uf", {31'd0, uf}, 32'd0);

    // first load on the second edge after reset release
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.D = 16'h0003;
    bus.D_VALID = 1'b1;
    tick();
    bus.D_VALID = 1'b0;
    check("first_edge_idle", {28'd0, q}, 32'd0);
    tick();
    check("second_edge_load", {28'd0, q}, 32'd3);
    repeat (4) tick();
    check("first_uf", {31'd0, uf}, 32'd1);
    clear_uf();

    // EN low during first word with second word held
    send_word(16'h00E4);
    send_word(16'h001B);
    check("en_s0", {28'd0, q}, 32'd0);
    en = 1'b0;
    tick();
    check("en_s1", {28'd0, q}, 32'd1);
    tick();
    check("en_s2", {28'd0, q}, 32'd2);
    tick();
    check("en_s3", {28'd0, q}, 32'd3);
    tick();
    check("en_idle_q", {28'd0, q}, 32'd0);
    check("en_idle_uf", {31'd0, uf}, 32'd0);
    check("en_idle_busy", {31'd0, busy}, 32'd1);
    check("en_idle_state", {31'd0, st}, {31'd0, IDLE});
    check("en_idle_ready", {31'd0, bus.D_READY}, 32'd0);
    tick();
    check("en_still_idle", {28'd0, q}, 32'd0);
    en = 1'b1;
    tick();
    check("en_w2_s0", {28'd0, q}, 32'd3);
    tick();
    check("en_w2_s1", {28'd0, q}, 32'd2);
    tick();
    check("en_w2_s2", {28'd0, q}, 32'd1);
    tick();
    check("en_w2_s3", {28'd0, q}, 32'd0);
    tick();
    check("en_w2_uf", {31'd0, uf}, 32'd1);
    clear_uf();

    // SDR, WIDTH=4, word 0xA
    bus_s.D = 4'hA;
    bus_s.D_VALID = 1'b1;
    check("sdr_ready", {31'd0, bus_s.D_READY}, 32'd1);
    tick();
    bus_s.D_VALID = 1'b0;
    check("sdr_pre", {30'd0, q_s}, 32'd0);
    tick();
    check("sdr_s0", {30'd0, q_s}, 32'd0);
    check("sdr_busy", {31'd0, busy_s}, 32'd1);
    tick();
    check("sdr_s1", {30'd0, q_s}, 32'd3);
    tick();
    check("sdr_s2", {30'd0, q_s}, 32'd0);
    tick();
    check("sdr_s3", {30'd0, q_s}, 32'd3);
    tick();
    check("sdr_idle", {30'd0, q_s}, 32'd0);
    check("sdr_uf", {31'd0, uf_s}, 32'd1);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
